// File: rtl/full_adder_3bits.sv
// full_adder_3bits: registered adder producing {Cout, Sum} = A + B + Cin.
// Build option FULL_ADDER_3BITS_CLA_EN swaps the ripple carry chain for a
// single-level carry-lookahead expansion. Both builds give identical results
// and latency; only the depth of the combinational carry path differs.
// The result is registered, so it appears one clock after the operands.
// The "3bits" in the name is historical; the datapath width is WIDTH.

module full_adder_3bits #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum
);

  logic [WIDTH-1:0] genBits;
  logic [WIDTH-1:0] propBits;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumComb;

  assign genBits  = A & B;
  assign propBits = A ^ B;

`ifdef FULL_ADDER_3BITS_CLA_EN
  // Flat lookahead: each carry is the OR of every generate term propagated up
  // to it, plus Cin propagated through all lower bits.
  always_comb begin
    logic acc;
    logic prod;
    carry    = '0;
    carry[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc = genBits[i];
      for (int j = 0; j < i; j++) begin
        prod = genBits[j];
        for (int k = j + 1; k <= i; k++) begin
          prod = prod & propBits[k];
        end
        acc = acc | prod;
      end
      prod = Cin;
      for (int k = 0; k <= i; k++) begin
        prod = prod & propBits[k];
      end
      acc = acc | prod;
      carry[i+1] = acc;
    end
  end
`else
  // Ripple chain: each cell generates its own carry or passes the incoming one.
  always_comb begin
    logic rippleCarry;
    carry       = '0;
    rippleCarry = Cin;
    carry[0]    = rippleCarry;
    for (int i = 0; i < WIDTH; i++) begin
      rippleCarry = genBits[i] | (rippleCarry & propBits[i]);
      carry[i+1]  = rippleCarry;
    end
  end
`endif

  assign sumComb = propBits ^ carry[WIDTH-1:0];

  // Result register; reset clears it immediately and discards any pending result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Cout <= 1'b0;
      Sum  <= '0;
    end else begin
      Cout <= carry[WIDTH];
      Sum  <= sumComb;
    end
  end

endmodule

// File: tb/tb_full_adder_3bits.sv
// Bench for full_adder_3bits: expected results are queued when operands are
// driven and popped when the registered output is sampled one edge later.
// A second pair of instances forms the two-stage A+B+C chain used by the ALU.

module tb_full_adder_3bits;

  localparam int WIDTH = 4;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Cout;
  logic [WIDTH-1:0] Sum;

  logic [WIDTH-1:0] chainA;
  logic [WIDTH-1:0] chainB;
  logic [WIDTH-1:0] chainC;
  logic             stage1Cout;
  logic [WIDTH-1:0] stage1Sum;
  logic             stage2Cout;
  logic [WIDTH-1:0] stage2Sum;

  logic [WIDTH:0] expectQ[$];
  int             errorCount;
  int             checkCount;

  full_adder_3bits #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Cout  (Cout),
    .Sum   (Sum)
  );

  full_adder_3bits #(.WIDTH(WIDTH)) chainStage1 (
    .clock (clock),
    .reset (reset),
    .A     (chainA),
    .B     (chainB),
    .Cin   (1'b0),
    .Cout  (stage1Cout),
    .Sum   (stage1Sum)
  );

  full_adder_3bits #(.WIDTH(WIDTH)) chainStage2 (
    .clock (clock),
    .reset (reset),
    .A     (stage1Sum),
    .B     (chainC),
    .Cin   (stage1Cout),
    .Cout  (stage2Cout),
    .Sum   (stage2Sum)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [WIDTH:0] observed,
                             input logic [WIDTH:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got {Cout,Sum}=%h, expected %h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive one operand set on the falling edge and queue its golden result.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c);
    logic [WIDTH:0] golden;
    @(negedge clock);
    A   = a;
    B   = b;
    Cin = c;
    golden = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    expectQ.push_back(golden);
  endtask

  // Let one rising edge load the operands, then compare against the queue head.
  task automatic stepAndCheck(input string tag);
    logic [WIDTH:0] expected;
    @(posedge clock);
    #1;
    expected = expectQ.pop_front();
    checkOutput(tag, {Cout, Sum}, expected);
  endtask

  initial begin
    logic [WIDTH:0] partial;
    logic [WIDTH:0] chainGolden;
    errorCount = 0;
    checkCount = 0;
    chainA = '0;
    chainB = '0;
    chainC = '0;

    // Reset held with all-ones operands: outputs must stay zero across edges.
    reset = 1'b0;
    A     = 4'hF;
    B     = 4'hF;
    Cin   = 1'b1;
    #2;
    checkOutput("resetInitial", {Cout, Sum}, 5'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("resetHold", {Cout, Sum}, 5'h00);
    end

    // Release reset; the next edge captures F+F+1.
    @(negedge clock);
    reset = 1'b1;
    expectQ.push_back(5'h1F);
    stepAndCheck("resetRelease");

    // Directed cases.
    applyStimulus(4'd3, 4'd5, 1'b0);
    stepAndCheck("basicAdd");
    applyStimulus(4'hF, 4'h1, 1'b0);
    stepAndCheck("wrapF1");
    applyStimulus(4'h8, 4'h8, 1'b1);
    stepAndCheck("wrap88c");
    applyStimulus(4'hF, 4'h0, 1'b1);
    stepAndCheck("carryChain");

    // Exhaustive sweep on back-to-back cycles.
    for (int k = 0; k < 512; k++) begin
      applyStimulus(4'(k >> 5), 4'(k >> 1), 1'(k));
      stepAndCheck("exhaustive");
    end

    // Mid-stream reset between two back-to-back operands.
    applyStimulus(4'd2, 4'd3, 1'b0);
    stepAndCheck("preReset");
    applyStimulus(4'd9, 4'd4, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midResetImmediate", {Cout, Sum}, 5'h00);
    expectQ.delete();
    @(posedge clock);
    #1;
    checkOutput("midResetDiscard", {Cout, Sum}, 5'h00);
    applyStimulus(4'd1, 4'd1, 1'b0);
    reset = 1'b1;
    stepAndCheck("postReset");

    // Two-instance chain: (A + B + 0), then (partial + C + first carry).
    @(negedge clock);
    chainA = 4'd7;
    chainB = 4'd6;
    chainC = 4'd9;
    partial     = {1'b0, chainA} + {1'b0, chainB};
    chainGolden = {1'b0, partial[WIDTH-1:0]} + {1'b0, chainC} +
                  {{WIDTH{1'b0}}, partial[WIDTH]};
    @(posedge clock);
    #1;
    checkOutput("chainStage1", {stage1Cout, stage1Sum}, partial);
    @(posedge clock);
    #1;
    checkOutput("chainStage2", {stage2Cout, stage2Sum}, chainGolden);
    checkOutput("chainConst", {stage2Cout, stage2Sum}, 5'h16);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
